// File: rtl/mac_accum_ctrl.sv
// Accumulate-and-control stage around an external 8x8+16 multiply-add (dadda_mult).
// Optional saturating accumulate is enabled by defining MAC_SAT_EN.
module mac_accum_ctrl #(
  parameter int unsigned N_TERMS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_a_i,
  input  logic [7:0]  in_b_i,
  output logic [7:0]  mac_a_o,
  output logic [7:0]  mac_b_o,
  output logic [15:0] mac_x_o,
  input  logic [15:0] mac_sum_i,
  input  logic        mac_cout_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_acc_o,
  output logic        out_ovf_o
);

  localparam logic [7:0] NTerms = 8'(N_TERMS);

  typedef enum logic [1:0] {StRun, StFlush, StHold} state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic        op_vld_q, op_vld_d;
  logic [15:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] acc_upd;
  logic        xfer;

`ifdef MAC_SAT_EN
  // A carry pins the sum at full scale; later carries keep it there.
  assign acc_upd = mac_cout_i ? 16'hFFFF : mac_sum_i;
`else
  assign acc_upd = mac_sum_i;
`endif

  assign xfer = in_valid_i & in_ready_o;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_vld_d = op_vld_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;

    if (op_vld_q) begin
      acc_d = acc_upd;
      ovf_d = ovf_q | mac_cout_i;
    end

    unique case (state_q)
      StRun: begin
        if (xfer) begin
          op_a_d   = in_a_i;
          op_b_d   = in_b_i;
          op_vld_d = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == NTerms) begin
            state_d = StFlush;
          end
        end else begin
          op_vld_d = 1'b0;
        end
      end
      StFlush: begin
        op_vld_d = 1'b0;
        state_d  = StHold;
      end
      StHold: begin
        if (out_ready_i) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // clr shares the reset path so a partial dot product is always discarded.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q  <= StRun;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_vld_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_vld_q <= op_vld_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Zero operands when idle so the multiplier output equals the accumulator.
  assign mac_a_o     = op_vld_q ? op_a_q : 8'd0;
  assign mac_b_o     = op_vld_q ? op_b_q : 8'd0;
  assign mac_x_o     = acc_q;
  assign in_ready_o  = (state_q == StRun);
  assign out_valid_o = (state_q == StHold);
  assign out_acc_o   = acc_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Directed bench for mac_accum_ctrl; two instances (4 and 2 terms) share the input stream.
module tb_mac_accum_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr, in_valid, out_ready;
  logic [7:0] in_a, in_b;

  logic        rdy4, oval4, ovf4, cout4;
  logic [7:0]  ma4, mb4;
  logic [15:0] mx4, sum4, oacc4;
  logic [16:0] p4;

  logic        rdy2, oval2, ovf2, cout2;
  logic [7:0]  ma2, mb2;
  logic [15:0] mx2, sum2, oacc2;
  logic [16:0] p2;

  // Behavioural stand-in for dadda_mult: {cout, sum} = a*b + x.
  assign p4    = 17'(ma4) * 17'(mb4) + 17'(mx4);
  assign sum4  = p4[15:0];
  assign cout4 = p4[16];
  assign p2    = 17'(ma2) * 17'(mb2) + 17'(mx2);
  assign sum2  = p2[15:0];
  assign cout2 = p2[16];

  mac_accum_ctrl #(.N_TERMS(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy4),
    .in_a_i(in_a), .in_b_i(in_b), .mac_a_o(ma4), .mac_b_o(mb4), .mac_x_o(mx4),
    .mac_sum_i(sum4), .mac_cout_i(cout4), .out_valid_o(oval4), .out_ready_i(out_ready),
    .out_acc_o(oacc4), .out_ovf_o(ovf4)
  );

  mac_accum_ctrl #(.N_TERMS(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .in_a_i(in_a), .in_b_i(in_b), .mac_a_o(ma2), .mac_b_o(mb2), .mac_x_o(mx2),
    .mac_sum_i(sum2), .mac_cout_i(cout2), .out_valid_o(oval2), .out_ready_i(out_ready),
    .out_acc_o(oacc2), .out_ovf_o(ovf2)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          gap;
    logic [15:0] exp_acc;
  } vec_t;

  vec_t vec [4];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_pulse();
    in_valid = 1'b0;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  logic [15:0] exp_ovf_acc;

  initial begin
    vec[0] = '{a: 8'd70, b: 8'd20,  gap: 2, exp_acc: 16'h0578};
    vec[1] = '{a: 8'd79, b: 8'd69,  gap: 0, exp_acc: 16'h1AC3};
    vec[2] = '{a: 8'd74, b: 8'd113, gap: 3, exp_acc: 16'h3B6D};
    vec[3] = '{a: 8'd93, b: 8'd7,   gap: 1, exp_acc: 16'h3DF8};
`ifdef MAC_SAT_EN
    exp_ovf_acc = 16'hFFFF;
`else
    exp_ovf_acc = 16'hA5F9;
`endif

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(rdy4), 32'd1);
    check("rst_out_valid", 32'(oval4), 32'd0);
    check("rst_out_acc", 32'(oacc4), 32'h0);
    check("rst_out_ovf", 32'(ovf4), 32'd0);
    check("rst_mac_x", 32'(mx4), 32'h0);
    check("rst_mac_a", 32'(ma4), 32'h0);

    // Back-to-back dot product
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = vec[i].a;
      in_b     = vec[i].b;
      step();
      check("dot_term_x", 32'(mx4), (i == 0) ? 32'h0 : 32'(vec[i-1].exp_acc));
      check("dot_in_ready", 32'(rdy4), (i == 3) ? 32'd0 : 32'd1);
    end
    in_valid = 1'b0;
    check("dot_flush_nvalid", 32'(oval4), 32'd0);
    step();
    check("dot_out_valid", 32'(oval4), 32'd1);
    check("dot_out_acc", 32'(oacc4), 32'h3DF8);
    check("dot_out_ovf", 32'(ovf4), 32'd0);
    step();
    check("dot_valid_drop", 32'(oval4), 32'd0);
    check("dot_ready_back", 32'(rdy4), 32'd1);
    check("dot_restart_x", 32'(mx4), 32'h0);

    // Overflow on the 2-term instance
    clr_pulse();
    send(8'd255, 8'd255);
    send(8'd215, 8'd200);
    check("ovf_flush_nvalid", 32'(oval2), 32'd0);
    step();
    check("ovf_out_valid", 32'(oval2), 32'd1);
    check("ovf_out_acc", 32'(oacc2), 32'(exp_ovf_acc));
    check("ovf_out_ovf", 32'(ovf2), 32'd1);
    step();
    check("ovf_cleared", 32'(ovf2), 32'd0);
    check("ovf_acc_cleared", 32'(mx2), 32'h0);

    // Backpressure in HOLD
    clr_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vec[i].a, vec[i].b);
    step();
    in_valid = 1'b1;
    in_a     = 8'd117;
    in_b     = 8'd120;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(rdy4), 32'd0);
      check("bp_out_valid", 32'(oval4), 32'd1);
      check("bp_out_acc", 32'(oacc4), 32'h3DF8);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_release_ready", 32'(rdy4), 32'd1);
    check("bp_release_valid", 32'(oval4), 32'd0);
    check("bp_release_x", 32'(mx4), 32'h0);
    step();
    in_valid = 1'b0;
    check("bp_accept_a", 32'(ma4), 32'd117);
    step();
    check("bp_fresh_acc", 32'(mx4), 32'h36D8);
    check("bp_idle_a", 32'(ma4), 32'd0);

    // Gapped input
    clr_pulse();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < vec[i].gap; g++) step();
      if (vec[i].gap > 0 && i > 0) check("gap_partial", 32'(mx4), 32'(vec[i-1].exp_acc));
      send(vec[i].a, vec[i].b);
    end
    step();
    check("gap_out_valid", 32'(oval4), 32'd1);
    check("gap_out_acc", 32'(oacc4), 32'h3DF8);
    check("gap_out_ovf", 32'(ovf4), 32'd0);
    step();

    // Mid-operation clear, with a transfer offered in the clear cycle
    clr_pulse();
    send(vec[0].a, vec[0].b);
    send(vec[1].a, vec[1].b);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_a     = 8'd9;
    in_b     = 8'd9;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_mac_a", 32'(ma4), 32'd0);
    check("clr_mac_x", 32'(mx4), 32'h0);
    check("clr_in_ready", 32'(rdy4), 32'd1);
    check("clr_out_valid", 32'(oval4), 32'd0);
    step();
    check("clr_dropped_x", 32'(mx4), 32'h0);
    for (int i = 0; i < 4; i++) send(8'd1, 8'd1);
    step();
    check("clr_out_valid2", 32'(oval4), 32'd1);
    check("clr_out_acc", 32'(oacc4), 32'h0004);
    check("clr_out_ovf", 32'(ovf4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
